// File: rtl/vga_pixel_arbiter_pkg.sv
// Shared constants and state encoding for the VGA pixel write-port arbiter.
package vga_pixel_arbiter_pkg;

  localparam int REQ_SCREEN = 0;
  localparam int REQ_COIN   = 1;
  localparam int REQ_CAR    = 2;
  localparam int REQ_ERASE  = 3;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vga_pixel_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after start, wrapping.
module rr_pick
  import vga_pixel_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic             hit_s;
  logic             any_s;
  logic [IDX_W-1:0] idx_s;

  // Scan requesters from start, latching the first one found.
  always_comb begin
    hit_s = 1'b0;
    any_s = 1'b0;
    idx_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      hit_s = req[(int'(start) + k) % N_REQ] && !any_s;
      idx_s = hit_s ? IDX_W'((int'(start) + k) % N_REQ) : idx_s;
      any_s = any_s | hit_s;
    end
  end

  assign grant = any_s ? (N_REQ'(1) << idx_s) : '0;
  assign idx   = idx_s;
  assign any   = any_s;

endmodule

// File: rtl/vga_pixel_arbiter.sv
// Round-robin arbiter with per-requester burst lock for the VGA adapter write port.
// Optional clipping of off-screen pixels is enabled by defining VGA_ARB_CLIP_EN.
module vga_pixel_arbiter
  import vga_pixel_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int COL_W = 3,
  parameter int X_MAX = SCREEN_W,
  parameter int Y_MAX = SCREEN_H
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*X_W-1:0]   x_in,
  input  logic [N_REQ*Y_W-1:0]   y_in,
  input  logic [N_REQ*COL_W-1:0] colour_in,
  output logic [N_REQ-1:0]       ack,
  output logic                   plot,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [COL_W-1:0]       colour,
  output logic [IDX_W-1:0]       owner,
  output logic                   locked
);

  arb_state_e       state_r, next_state_s;
  logic [IDX_W-1:0] owner_r, next_owner_s, start_s, sel_s, rr_idx_s;
  logic [N_REQ-1:0] rr_grant_s, ack_s;
  logic             rr_any_s, accept_s, in_range_s, write_s;
  logic [X_W-1:0]   sel_x_s, x_r;
  logic [Y_W-1:0]   sel_y_s, y_r;
  logic [COL_W-1:0] sel_col_s, colour_r;
  logic             plot_r;

  assign start_s = (owner_r == IDX_W'(N_REQ-1)) ? '0 : owner_r + IDX_W'(1);

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req   (req),
    .start (start_s),
    .grant (rr_grant_s),
    .idx   (rr_idx_s),
    .any   (rr_any_s)
  );

  // Grant decision and next state; a zero lock always leaves LOCKED.
  always_comb begin
    ack_s        = '0;
    accept_s     = 1'b0;
    sel_s        = owner_r;
    next_owner_s = owner_r;
    next_state_s = state_r;
    case (state_r)
      OPEN: begin
        if (rr_any_s) begin
          ack_s        = rr_grant_s;
          accept_s     = 1'b1;
          sel_s        = rr_idx_s;
          next_owner_s = rr_idx_s;
          next_state_s = lock[rr_idx_s] ? LOCKED : OPEN;
        end else begin
          next_state_s = OPEN;
        end
      end
      LOCKED: begin
        ack_s[owner_r] = req[owner_r];
        accept_s       = req[owner_r];
        next_state_s   = lock[owner_r] ? LOCKED : OPEN;
      end
      default: begin
        next_state_s = OPEN;
      end
    endcase
  end

  assign sel_x_s   = x_in[sel_s*X_W +: X_W];
  assign sel_y_s   = y_in[sel_s*Y_W +: Y_W];
  assign sel_col_s = colour_in[sel_s*COL_W +: COL_W];

`ifdef VGA_ARB_CLIP_EN
  assign in_range_s = (int'(sel_x_s) < X_MAX) && (int'(sel_y_s) < Y_MAX);
`else
  assign in_range_s = 1'b1;
`endif

  assign write_s = accept_s && in_range_s;

  // FSM state and owner pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= OPEN;
      owner_r <= IDX_W'(N_REQ-1);
    end else begin
      state_r <= next_state_s;
      owner_r <= next_owner_s;
    end
  end

  // Registered pixel write toward the adapter; coordinates hold when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot_r   <= 1'b0;
      x_r      <= '0;
      y_r      <= '0;
      colour_r <= '0;
    end else begin
      plot_r <= write_s;
      if (write_s) begin
        x_r      <= sel_x_s;
        y_r      <= sel_y_s;
        colour_r <= sel_col_s;
      end else begin
        x_r      <= x_r;
        y_r      <= y_r;
        colour_r <= colour_r;
      end
    end
  end

  // Requesters advance on ack, so ack must be quiet during reset.
  assign ack    = resetn ? ack_s : '0;
  assign plot   = plot_r;
  assign x      = x_r;
  assign y      = y_r;
  assign colour = colour_r;
  assign owner  = owner_r;
  assign locked = (state_r == LOCKED);

endmodule

// File: doc/vga_pixel_arbiter.md
# vga_pixel_arbiter

Shares the single VGA adapter write port (plot, x, y, colour) among the drawing engines that the animation controller sequences: screen painter, coin painter, car painter and car eraser. Each engine presents one pixel per cycle with a request, and the arbiter accepts at most one pixel per cycle. It drives one registered pixel write toward the adapter. Round-robin selection gives fairness. A per-requester lock lets an engine own the port for a whole sprite or screen burst.

## Interface
- N_REQ, 4, number of requesters; index 0 = screen, 1 = coin, 2 = car, 3 = erase.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COL_W, 3, colour width.
- X_MAX, 160, screen width in pixels; used only for clipping.
- Y_MAX, 120, screen height in pixels; used only for clipping.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; one clock, asynchronous assertion, active-low.
- req  in  N_REQ  per-requester pixel valid.
- lock  in  N_REQ  per-requester burst hold.
- x_in  in  N_REQ*X_W  packed x; requester i occupies bits [i*X_W +: X_W].
- y_in  in  N_REQ*Y_W  packed y, packed the same way.
- colour_in  in  N_REQ*COL_W  packed colour, packed the same way.
- ack  out  N_REQ  combinational one-hot pixel accepted this cycle.
- plot  out  1  registered write strobe to the adapter.
- x  out  X_W  registered pixel x.
- y  out  Y_W  registered pixel y.
- colour  out  COL_W  registered pixel colour.
- owner  out  2  index of the last granted requester.
- locked  out  1  high while in the LOCKED state.

## Operation
- FSM states:
  - OPEN: round-robin among all requesters.
  - LOCKED: only `owner` is served.
- Round-robin in OPEN:
  - The search starts at (owner+1) mod N_REQ and wraps around.
  - The first i with req[i]=1 wins.
  - ack[winner]=1 and owner<=winner.
  - No req means no ack, and owner is held.
- OPEN→LOCKED: the winner has lock=1 in its grant cycle.
- LOCKED, each cycle:
  - ack[owner]=req[owner]; all other acks are 0 and those requesters stall (hold their inputs).
  - lock[owner]=1 with req=0 holds the port idle with no plot.
  - lock[owner]=0 returns the FSM to OPEN next cycle. If req[owner]=1 in that same cycle, its pixel is still accepted.
- An accepted pixel is written next cycle: plot=1 with the winner's x/y/colour. Otherwise plot=0 and x/y/colour hold their previous values.
- ack depends on req and lock, and on state, in the same cycle. Requesters advance their pixel on ack.
- Reset values:
  - plot=0, x=0, y=0, colour=0.
  - owner=N_REQ-1, so requester 0 wins first.
  - locked=0, state OPEN.
  - ack is forced to 0 while resetn=0.
- Reset mid-burst aborts immediately with no partial plot. State returns to OPEN.

## Timing
- Latency from ack to plot is 1 cycle. Throughput is 1 pixel per cycle sustained.
- Simultaneous requests are served in round-robin order. Four continuous requesters each get exactly 1 of every 4 cycles.
- Lock on a non-winning requester has no effect until that requester wins.
- Lock released and re-asserted in the same cycle is not possible: lock is sampled once per cycle, and lock=0 always leaves LOCKED.
- A back-to-back lock by the same owner after release is allowed. It is arbitrated fresh in OPEN, so requester owner+1 gets priority if it is requesting.

## Configuration
- VGA_ARB_CLIP_EN defined:
  - An accepted pixel with x ≥ X_MAX or y ≥ Y_MAX is still acked (the requester advances), but plot stays 0 for it.
  - The x/y/colour registers do not update for a clipped pixel.
- VGA_ARB_CLIP_EN undefined: every accepted pixel is plotted unchanged, and out-of-range pixels are the adapter's responsibility.

## Structure
- Shared package holds:
  - the requester index constants REQ_SCREEN=0, REQ_COIN=1, REQ_CAR=2, REQ_ERASE=3;
  - the screen-size constants (160, 120);
  - the state encoding OPEN/LOCKED.
- One sub-module, rr_pick: combinational round-robin selector. Inputs are req and start pointer; outputs are one-hot grant, index and any-valid.
- The top level holds the FSM, owner register, output registers and clip logic.

## Test plan
- Single requester: req[2]=1 at (10,20,colour 5) for one cycle → ack=4'b0100 that cycle; next cycle plot=1, x=10, y=20, colour=5, owner=2.
- Fairness: all four req held high for 8 cycles from reset → ack sequence 0,1,2,3,0,1,2,3; eight plots.
- Lock burst: req[1] and lock[1] high for 5 cycles while req[3] is also high → 5 consecutive acks to 1, req[3] stalled. After lock[1] falls, req[3] is acked on the next cycle.
- Lock idle: lock[0]=1, req[0]=0 for 3 cycles with req[2]=1 → no ack, plot=0, locked=1 throughout.
- Reset mid-burst: resetn pulled low during a locked burst → plot=0 and ack=0 immediately, locked=0. After release the first grant goes to requester 0.
- Clip (with VGA_ARB_CLIP_EN): pixel (165,5) acked → plot stays 0. Without the macro → plot=1, x=165.
